dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory between the RISC-V core's load/store path and a DMA/debug port. It sits between the core and the data memory in the top level. Core accesses win by default. A starvation counter guarantees DMA progress, and an optional lock mode lets the DMA hold the memory for a bounded burst. Grants are combinational from registered arbitration state, so the single-cycle core stalls only on cycles where it loses.

---
 rtl/dmem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core load/store
// path and a DMA/debug port. The core wins by default; a starvation counter
// promotes the DMA after STARVE_LIMIT denied cycles.
// Optional burst lock is built only when DMEM_ARB_LOCK_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// CORE_PRI | core owns priority, DMA served on idle core cycles
// DMA_PRI  | DMA promoted by starvation, owns priority for one grant
// DMA_LOCK | DMA holds priority for a locked burst (lock build only)

module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_lock,
    output logic        d_gnt,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

`ifdef DMEM_ARB_LOCK_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        CORE_PRI = 2'd0,
        DMA_PRI  = 2'd1,
        DMA_LOCK = 2'd2
    } state_t;

    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_next;
`else
    typedef enum logic [1:0] {
        CORE_PRI = 2'd0,
        DMA_PRI  = 2'd1
    } state_t;

    logic unused_lock;
    assign unused_lock = d_lock;
`endif

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_next;

    // Grants depend only on registered state and requests, never on mem_rdata.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (state == CORE_PRI) begin
                c_gnt = c_req;
                d_gnt = d_req & ~c_req;
            end else begin
                d_gnt = d_req;
                c_gnt = c_req & ~d_req;
            end
        end
    end

    // Route the granted port to the memory; idle bus drives zeros.
    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_we    = 1'b0;
        if (c_gnt) begin
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            mem_we    = c_we;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = d_we;
        end
    end

    assign c_rdata = (c_gnt & ~c_we) ? mem_rdata : 32'd0;
    assign d_rdata = (d_gnt & ~d_we) ? mem_rdata : 32'd0;

    // Count consecutive denied DMA cycles, saturating at the limit.
    always_comb begin
        starve_next = starve_cnt;
        if (!d_req || d_gnt) begin
            starve_next = '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_next = starve_cnt + SW'(1);
        end
    end

    // Priority ownership transitions.
    always_comb begin
        state_next = state;
`ifdef DMEM_ARB_LOCK_EN
        burst_next = burst_cnt;
`endif
        case (state)
            CORE_PRI: begin
`ifdef DMEM_ARB_LOCK_EN
                if (d_gnt && d_lock) begin
                    state_next = DMA_LOCK;
                    burst_next = BW'(1);
                end else
`endif
                if (starve_next == STARVE_MAX) begin
                    state_next = DMA_PRI;
                end
            end
            DMA_PRI: begin
`ifdef DMEM_ARB_LOCK_EN
                if (d_gnt && d_lock) begin
                    state_next = DMA_LOCK;
                    burst_next = BW'(1);
                end else
`endif
                if (d_gnt || !d_req) begin
                    state_next = CORE_PRI;
                end
            end
`ifdef DMEM_ARB_LOCK_EN
            DMA_LOCK: begin
                if (!d_lock || !d_req) begin
                    state_next = CORE_PRI;
                    burst_next = '0;
                end else if (d_gnt) begin
                    // Forced release: the core gets priority for at least one cycle.
                    if (burst_cnt == BURST_LAST) begin
                        state_next = CORE_PRI;
                        burst_next = '0;
                    end else begin
                        burst_next = burst_cnt + BW'(1);
                    end
                end
            end
`endif
            default: state_next = CORE_PRI;
        endcase
    end

    // Arbitration state registers; reset aborts any burst in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CORE_PRI;
            starve_cnt <= '0;
`ifdef DMEM_ARB_LOCK_EN
            burst_cnt  <= '0;
`endif
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
`ifdef DMEM_ARB_LOCK_EN
            burst_cnt  <= burst_next;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
// Expectations follow the DMEM_ARB_LOCK_EN setting of the build.

module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        c_req, c_we, c_gnt;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        d_req, d_we, d_lock, d_gnt;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:63];

    dmem_arbiter #(.STARVE_LIMIT(4), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_lock(d_lock), .d_gnt(d_gnt), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h4; c_wdata = 32'h1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (c_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_we !== 1'b0) begin
                $display("FAIL reset_gnt cyc=%0d got c=%b d=%b we=%b exp 0 0 0", i, c_gnt, d_gnt, mem_we);
                bad++;
            end
            total++;
            if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
                $display("FAIL reset_bus cyc=%0d got addr=%h wdata=%h exp 0", i, mem_addr, mem_wdata);
                bad++;
            end
            cyc();
        end
        reset = 1'b0; c_we = 1'b0; d_we = 1'b0;
        @(negedge clk);
        total++;
        if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            $display("FAIL reset_first got c=%b d=%b exp c=1 d=0", c_gnt, d_gnt);
            bad++;
        end
        cyc();
        c_req = 1'b0; d_req = 1'b0;
        cyc();
    endtask

    task automatic test_core_store_load();
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if (c_gnt !== 1'b1 || mem_we !== 1'b1) begin
            $display("FAIL core_store got gnt=%b we=%b exp 1 1", c_gnt, mem_we);
            bad++;
        end
        total++;
        if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
            $display("FAIL core_store_bus got addr=%h wdata=%h exp 10 deadbeef", mem_addr, mem_wdata);
            bad++;
        end
        cyc();
        c_we = 1'b0; c_wdata = 32'd0;
        @(negedge clk);
        total++;
        if (c_gnt !== 1'b1 || c_rdata !== 32'hDEADBEEF || mem_we !== 1'b0) begin
            $display("FAIL core_load got gnt=%b rdata=%h we=%b exp 1 deadbeef 0", c_gnt, c_rdata, mem_we);
            bad++;
        end
        total++;
        if (d_rdata !== 32'd0) begin
            $display("FAIL core_load_drdata got %h exp 0", d_rdata);
            bad++;
        end
        cyc();
        c_req = 1'b0;
        cyc();
    endtask

    task automatic test_dma_idle_core();
        @(negedge clk);
        total++;
        if (c_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 || c_rdata !== 32'd0) begin
            $display("FAIL idle_bus got c=%b d=%b we=%b addr=%h crd=%h exp all 0", c_gnt, d_gnt, mem_we, mem_addr, c_rdata);
            bad++;
        end
        cyc();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; d_lock = 1'b0;
        @(negedge clk);
        total++;
        if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20) begin
            $display("FAIL dma_store got gnt=%b we=%b addr=%h exp 1 1 20", d_gnt, mem_we, mem_addr);
            bad++;
        end
        cyc();
        d_we = 1'b0; d_wdata = 32'd0;
        @(negedge clk);
        total++;
        if (d_gnt !== 1'b1 || d_rdata !== 32'h12345678 || c_rdata !== 32'd0) begin
            $display("FAIL dma_load got gnt=%b rdata=%h crd=%h exp 1 12345678 0", d_gnt, d_rdata, c_rdata);
            bad++;
        end
        cyc();
        d_req = 1'b0;
        cyc();
    endtask

    task automatic test_starvation();
        logic exp_d;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_lock = 1'b0;
        for (int i = 0; i < 15; i++) begin
            exp_d = ((i % 5) == 4);
            @(negedge clk);
            total++;
            if (c_gnt !== ~exp_d || d_gnt !== exp_d) begin
                $display("FAIL starve_pattern cyc=%0d got c=%b d=%b exp c=%b d=%b", i, c_gnt, d_gnt, ~exp_d, exp_d);
                bad++;
            end
            total++;
            if (mem_addr !== (exp_d ? 32'h200 : 32'h100)) begin
                $display("FAIL starve_addr cyc=%0d got %h exp %h", i, mem_addr, exp_d ? 32'h200 : 32'h100);
                bad++;
            end
            cyc();
        end
        c_req = 1'b0; d_req = 1'b0;
        cyc();
    endtask

    task automatic test_lock_burst();
        logic exp_d;
        logic [31:0] exp_rd;
        int beat;
        beat = 0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h100;
        d_req = 1'b1; d_lock = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (beat == 0) begin
                d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hA5A50001;
            end else if (beat == 1) begin
                d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'hA5A50002;
            end else begin
                d_we = 1'b0; d_wdata = 32'd0;
                d_addr = ((beat % 2) == 1) ? 32'h44 : 32'h40;
            end
`ifdef DMEM_ARB_LOCK_EN
            exp_d = (i >= 4 && i <= 11);
`else
            exp_d = ((i % 5) == 4);
`endif
            @(negedge clk);
            total++;
            if (c_gnt !== ~exp_d || d_gnt !== exp_d) begin
                $display("FAIL lock_pattern cyc=%0d got c=%b d=%b exp c=%b d=%b", i, c_gnt, d_gnt, ~exp_d, exp_d);
                bad++;
            end
            if (exp_d && beat >= 2) begin
                exp_rd = ((beat % 2) == 1) ? 32'hA5A50002 : 32'hA5A50001;
                total++;
                if (d_rdata !== exp_rd) begin
                    $display("FAIL lock_readback beat=%0d got %h exp %h", beat, d_rdata, exp_rd);
                    bad++;
                end
            end
            if (exp_d) beat++;
            cyc();
        end
        c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0; d_we = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_burst();
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h84; c_wdata = 32'h11110000;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h22220000; d_lock = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                reset = 1'b1;
                c_wdata = 32'h44444444;
                d_wdata = 32'h33333333;
            end
            @(negedge clk);
            if (i == 6) begin
                total++;
                if (mem_we !== 1'b0 || c_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_addr !== 32'd0) begin
                    $display("FAIL midburst_reset got we=%b c=%b d=%b addr=%h exp 0 0 0 0", mem_we, c_gnt, d_gnt, mem_addr);
                    bad++;
                end
            end
            cyc();
        end
        total++;
        if (mem[32] !== 32'h22220000 || mem[33] !== 32'h11110000) begin
            $display("FAIL midburst_nowrite got m80=%h m84=%h exp 22220000 11110000", mem[32], mem[33]);
            bad++;
        end
        reset = 1'b0; c_we = 1'b0; d_we = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            total++;
            if (c_gnt !== (j < 4) || d_gnt !== (j == 4)) begin
                $display("FAIL after_reset cyc=%0d got c=%b d=%b exp c=%b d=%b", j, c_gnt, d_gnt, j < 4, j == 4);
                bad++;
            end
            cyc();
        end
        c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = 32'd0; c_wdata = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_lock = 1'b0;
        cyc();
        test_reset();
        test_core_store_load();
        test_dma_idle_core();
        test_starvation();
        test_lock_burst();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
